prog_loader: RTL and testbench

- Boot-time writer for the CPU's 2048x16 main memory. It fills the memory that the processor later reads.
- Accepts a framed byte stream on a valid/ready interface and writes 16-bit words to addresses 0..N-1 through the memory write port (wea/addra/dina).
- Holds the processor in reset until a frame loads with a correct checksum, then releases it.
- The top level muxes the memory port to this block while cpu_reset is high.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream and memory-write bundle between the boot loader and its surroundings.
// The master side feeds bytes and observes the writes; the slave side is the loader itself.
interface prog_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_wen, mem_addr, mem_din, cpu_reset, done, error, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_wen, mem_addr, mem_din, cpu_reset, done, error, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: parses a SYNC/LEN/data/CHK byte frame and writes words into main memory,
// holding the CPU in reset until a frame with a good checksum has been stored.
module prog_loader #(
    parameter int         ADDR_W = 11,
    parameter int         DATA_W = 16,
    parameter int         DEPTH  = 2048,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, LEN_H, LEN_L, D_HI, D_LO, WRITE, CHECK, DONE, ERROR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state;
    logic [15:0] len;
    logic [7:0]  chk;
    logic        accept;
    logic [15:0] len_next;
    logic [16:0] words_next;

    assign accept     = bus.rx_valid && bus.rx_ready;
    assign len_next   = {len[15:8], bus.rx_data};
    assign words_next = 17'(bus.words_loaded) + 17'd1;

    // rx_ready is updated alongside every transition so it always reflects the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            len              <= '0;
            chk              <= '0;
            bus.rx_ready     <= 1'b0;
            bus.mem_wen      <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_din      <= '0;
            bus.cpu_reset    <= 1'b1;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
            bus.words_loaded <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rx_ready <= 1'b1;
                    if (accept && bus.rx_data == SYNC) begin
                        state <= LEN_H;
                        chk   <= '0;
                    end
                end
                LEN_H: begin
                    if (accept) begin
                        len[15:8] <= bus.rx_data;
                        chk       <= chk ^ bus.rx_data;
                        state     <= LEN_L;
                    end
                end
                LEN_L: begin
                    if (accept) begin
                        len <= len_next;
                        chk <= chk ^ bus.rx_data;
                        if (len_next == 16'd0 || {1'b0, len_next} > DEPTH_L) begin
                            state        <= ERROR;
                            bus.rx_ready <= 1'b0;
                            bus.error    <= 1'b1;
                        end else begin
                            state <= D_HI;
                        end
                    end
                end
                D_HI: begin
                    if (accept) begin
                        bus.mem_din[DATA_W-1 -: 8] <= bus.rx_data;
                        chk                        <= chk ^ bus.rx_data;
                        state                      <= D_LO;
                    end
                end
                D_LO: begin
                    if (accept) begin
                        bus.mem_din[7:0] <= bus.rx_data;
                        chk              <= chk ^ bus.rx_data;
                        state            <= WRITE;
                        bus.rx_ready     <= 1'b0;
                        bus.mem_wen      <= 1'b1;
                    end
                end
                WRITE: begin
                    bus.mem_wen      <= 1'b0;
                    bus.rx_ready     <= 1'b1;
                    bus.mem_addr     <= bus.mem_addr + 1'b1;
                    bus.words_loaded <= bus.words_loaded + 1'b1;
                    if (words_next == {1'b0, len}) begin
                        state <= CHECK;
                    end else begin
                        state <= D_HI;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == chk) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
                        end else begin
                            state     <= ERROR;
                            bus.error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.rx_ready <= 1'b0;
                end
                ERROR: begin
                    bus.rx_ready <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.rx_ready <= 1'b0;
                    bus.mem_wen  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are streamed byte by byte and every memory write
// is captured on the falling edge for comparison with hand-computed expectations.
module tb_prog_loader;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    prog_loader #(.ADDR_W(11), .DATA_W(16), .DEPTH(2048), .SYNC(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ready_in_write = 0;
    int both_flags = 0;
    logic [10:0] log_addr[$];
    logic [15:0] log_data[$];
    logic [7:0]  tx_q[$];

    always @(negedge clk) begin
        if (bus.mem_wen === 1'b1) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_din);
            if (bus.rx_ready !== 1'b0) ready_in_write++;
        end
        if (bus.done === 1'b1 && bus.error === 1'b1) both_flags++;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        ready_in_write = 0;
        both_flags = 0;
    endtask

    task automatic do_reset(input int cycles);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge right after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_byte_timeout byte=%h rx_ready never rose within 200 cycles", b);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input int gap);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (gap > 0 && i != tx_q.size() - 1) begin
                bus.rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.mem_wen, bus.cpu_reset, bus.done, bus.error} !== 5'b00100) begin
            failures++;
            $display("[TB] FAIL reset_flags got rdy/wen/cpurst/done/err=%b expected 00100",
                     {bus.rx_ready, bus.mem_wen, bus.cpu_reset, bus.done, bus.error});
        end
        checks++;
        if (bus.mem_addr !== 11'd0 || bus.mem_din !== 16'd0 || bus.words_loaded !== 12'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs got addr=%0d din=%h words=%0d expected 0/0000/0",
                     bus.mem_addr, bus.mem_din, bus.words_loaded);
        end
        bus.rx_valid = 1'b0;
        reset = 1'b0;
    endtask

    // XOR of 00 02 12 34 AB CD is 0x42, so that is the good checksum for this frame.
    task automatic test_happy_path();
        do_reset(2);
        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        applyStimulus(0);
        checks++;
        if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1) begin
            failures++;
            $display("[TB] FAIL happy_before_chk got done=%b cpu_reset=%b expected 0/1",
                     bus.done, bus.cpu_reset);
        end
        send_byte(8'h42);
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL happy_done got done=%b cpu_reset=%b error=%b expected 1/0/0",
                     bus.done, bus.cpu_reset, bus.error);
        end
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 11'd0 || log_data[0] !== 16'h1234 ||
            log_addr[1] !== 11'd1 || log_data[1] !== 16'hABCD) begin
            failures++;
            $display("[TB] FAIL happy_writes got n=%0d first=%0d:%h last=%0d:%h expected 2 0:1234 1:abcd",
                     log_addr.size(), log_addr[0], log_data[0], log_addr[$], log_data[$]);
        end
        checks++;
        if (bus.words_loaded !== 12'd2 || ready_in_write != 0) begin
            failures++;
            $display("[TB] FAIL happy_count got words=%0d ready_in_write=%0d expected 2/0",
                     bus.words_loaded, ready_in_write);
        end
    endtask

    task automatic test_garbage();
        do_reset(2);
        clear_log();
        tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        applyStimulus(0);
        checks++;
        if (log_addr.size() != 2 || log_data[0] !== 16'h1234 || log_data[1] !== 16'hABCD ||
            bus.done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL garbage got n=%0d d0=%h d1=%h done=%b expected 2 1234 abcd 1",
                     log_addr.size(), log_data[0], log_data[1], bus.done);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset(2);
        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        applyStimulus(0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.rx_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bad_chk_flags got err=%b done=%b cpu_reset=%b rdy=%b expected 1/0/1/0",
                     bus.error, bus.done, bus.cpu_reset, bus.rx_ready);
        end
        checks++;
        if (log_addr.size() != 2 || both_flags != 0) begin
            failures++;
            $display("[TB] FAIL bad_chk_writes got n=%0d both_flags=%0d expected 2/0",
                     log_addr.size(), both_flags);
        end
    endtask

    task automatic test_len_bounds();
        do_reset(2);
        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'h00};
        applyStimulus(0);
        checks++;
        if (bus.error !== 1'b1 || bus.rx_ready !== 1'b0 || log_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL len_zero got err=%b rdy=%b writes=%0d expected 1/0/0",
                     bus.error, bus.rx_ready, log_addr.size());
        end
        do_reset(2);
        clear_log();
        tx_q = '{8'hA5, 8'h08, 8'h01};
        applyStimulus(0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.done !== 1'b0 || log_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL len_over got err=%b done=%b writes=%0d expected 1/0/0",
                     bus.error, bus.done, log_addr.size());
        end
    endtask

    task automatic test_len_max();
        logic [15:0] w;
        logic [15:0] expd[$];
        logic [7:0]  sum;
        int bad;
        do_reset(2);
        clear_log();
        sum = 8'h08 ^ 8'h00;
        tx_q = '{8'hA5, 8'h08, 8'h00};
        for (int i = 0; i < 2048; i++) begin
            w = 16'(i * 40503);
            expd.push_back(w);
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
            sum = sum ^ w[15:8] ^ w[7:0];
        end
        tx_q.push_back(sum);
        applyStimulus(0);
        bad = 0;
        foreach (log_addr[i]) begin
            if (i < 2048 && (log_addr[i] !== 11'(i) || log_data[i] !== expd[i])) bad++;
        end
        checks++;
        if (log_addr.size() != 2048 || bad != 0 || log_addr[$] !== 11'd2047) begin
            failures++;
            $display("[TB] FAIL len_max_writes got n=%0d bad=%0d last_addr=%0d expected 2048/0/2047",
                     log_addr.size(), bad, log_addr[$]);
        end
        checks++;
        if (bus.words_loaded !== 12'd2048 || bus.done !== 1'b1 || bus.mem_addr !== 11'd0) begin
            failures++;
            $display("[TB] FAIL len_max_state got words=%0d done=%b addr=%0d expected 2048/1/0",
                     bus.words_loaded, bus.done, bus.mem_addr);
        end
    endtask

    // Checksum of 00 03 11 22 33 44 55 66 is 0x74.
    task automatic test_back_to_back();
        do_reset(2);
        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h74};
        applyStimulus(5);
        checks++;
        if (log_addr.size() != 3 || log_data[0] !== 16'h1122 || log_data[1] !== 16'h3344 ||
            log_data[2] !== 16'h5566 || log_addr[2] !== 11'd2) begin
            failures++;
            $display("[TB] FAIL gaps_writes got n=%0d d=%h %h %h a2=%0d expected 3 1122 3344 5566 2",
                     log_addr.size(), log_data[0], log_data[1], log_data[2], log_addr[2]);
        end
        checks++;
        if (ready_in_write != 0 || bus.done !== 1'b1 || bus.words_loaded !== 12'd3) begin
            failures++;
            $display("[TB] FAIL gaps_state got ready_in_write=%0d done=%b words=%0d expected 0/1/3",
                     ready_in_write, bus.done, bus.words_loaded);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(2);
        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        applyStimulus(0);
        @(negedge clk);
        checks++;
        if (bus.words_loaded !== 12'd1 || log_addr.size() != 1) begin
            failures++;
            $display("[TB] FAIL mid_first_write got words=%0d writes=%0d expected 1/1",
                     bus.words_loaded, log_addr.size());
        end
        do_reset(1);
        checks++;
        if (bus.words_loaded !== 12'd0 || bus.mem_addr !== 11'd0 || bus.cpu_reset !== 1'b1 ||
            bus.rx_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset got words=%0d addr=%0d cpu_reset=%b rdy=%b expected 0/0/1/0",
                     bus.words_loaded, bus.mem_addr, bus.cpu_reset, bus.rx_ready);
        end
        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
        applyStimulus(0);
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 11'd0 || log_data[0] !== 16'hBEEF ||
            bus.done !== 1'b1 || bus.error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reload got n=%0d a=%0d d=%h done=%b err=%b expected 1 0 beef 1 0",
                     log_addr.size(), log_addr[0], log_data[0], bus.done, bus.error);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_happy_path();
        test_garbage();
        test_bad_checksum();
        test_len_bounds();
        test_len_max();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
